mm_read_ctrl: RTL and testbench

//  Read-side sequencer for the ping-pong operand buffers: in the multiply clock domain it generates the
//  rd_addr_A/rd_addr_B streams and read enable, then pulses done_read_control per B block and done_multiply

---
 rtl/mm_rd_ctrl_pkg.sv | 21 ++
 rtl/mm_read_ctrl_if.sv | 36 +++
 rtl/mm_addr_walker.sv | 83 ++++++++
 rtl/mm_read_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mm_read_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_rd_ctrl_pkg.sv
// rtl/mm_rd_ctrl_pkg.sv - shared state type and widths for the multiply-domain read sequencer
package mm_rd_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BLK,
        READ,
        BLK_DONE,
        DRAIN,
        DONE
    } state_e;

    localparam int PERF_W = 32;
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mm_read_ctrl_if.sv
// rtl/mm_read_ctrl_if.sv - session control, operand-read stream and status between buffers and array
interface mm_read_ctrl_if #(
    parameter int ADDR_W_A     = 12,
    parameter int ADDR_W_B     = 12,
    parameter int MATRIXSIZE_W = 16
);
    import mm_rd_ctrl_pkg::*;

    logic                    start_multiply;
    logic                    blk_ready;
    logic [MATRIXSIZE_W-1:0] M2;
    logic [MATRIXSIZE_W-1:0] M1dN1;
    logic [MATRIXSIZE_W-1:0] BLOCK_WIDTHdN2;
    logic [MATRIXSIZE_W-1:0] BLOCKS;
    logic [ADDR_W_A-1:0]     rd_addr_A;
    logic [ADDR_W_B-1:0]     rd_addr_B;
    logic                    rd_en;
    logic                    tile_first;
    logic                    tile_last;
    logic                    done_read_control;
    logic                    done_multiply;
    logic [PERF_W-1:0]       perf_stall_cycles;

    modport master (
        input  start_multiply, blk_ready, M2, M1dN1, BLOCK_WIDTHdN2, BLOCKS,
        output rd_addr_A, rd_addr_B, rd_en, tile_first, tile_last,
               done_read_control, done_multiply, perf_stall_cycles
    );

    modport slave (
        output start_multiply, blk_ready, M2, M1dN1, BLOCK_WIDTHdN2, BLOCKS,
        input  rd_addr_A, rd_addr_B, rd_en, tile_first, tile_last,
               done_read_control, done_multiply, perf_stall_cycles
    );

endinterface

// File: rtl/mm_addr_walker.sv
// rtl/mm_addr_walker.sv - i/j/k walk over one B block with base accumulators instead of multipliers
module mm_addr_walker #(
    parameter int ADDR_W_A     = 12,
    parameter int ADDR_W_B     = 12,
    parameter int MATRIXSIZE_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic                    step_i,
    input  logic [MATRIXSIZE_W-1:0] m2_i,
    input  logic [MATRIXSIZE_W-1:0] m1_i,
    input  logic [MATRIXSIZE_W-1:0] bw_i,
    output logic [ADDR_W_A-1:0]     addr_a_o,
    output logic [ADDR_W_B-1:0]     addr_b_o,
    output logic                    first_o,
    output logic                    last_o,
    output logic                    zero_o,
    output logic                    done_o
);
    localparam logic [MATRIXSIZE_W-1:0] ONE = MATRIXSIZE_W'(1);

    logic [MATRIXSIZE_W-1:0] m2_q, m1_q, bw_q;
    logic [MATRIXSIZE_W-1:0] i_q, j_q, k_q;
    logic [ADDR_W_A-1:0]     base_a_q;
    logic [ADDR_W_B-1:0]     base_b_q;
    logic                    k_wrap, j_wrap, i_wrap;

    assign k_wrap = (k_q == m2_q - ONE);
    assign j_wrap = (j_q == bw_q - ONE);
    assign i_wrap = (i_q == m1_q - ONE);

    // Bases already hold i*M2 and j*M2 modulo the bank size; adding k finishes the address.
    assign addr_a_o = base_a_q + ADDR_W_A'(k_q);
    assign addr_b_o = base_b_q + ADDR_W_B'(k_q);
    assign first_o  = (k_q == '0);
    assign last_o   = k_wrap;
    assign zero_o   = (m2_q == '0) || (m1_q == '0) || (bw_q == '0);
    assign done_o   = k_wrap && j_wrap && i_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            m2_q     <= '0;
            m1_q     <= '0;
            bw_q     <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
        end else if (load_i) begin
            m2_q     <= m2_i;
            m1_q     <= m1_i;
            bw_q     <= bw_i;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
        end else if (step_i) begin
            if (k_wrap) begin
                k_q <= '0;
                if (j_wrap) begin
                    j_q      <= '0;
                    base_b_q <= '0;
                    if (i_wrap) begin
                        i_q      <= '0;
                        base_a_q <= '0;
                    end else begin
                        i_q      <= i_q + ONE;
                        base_a_q <= base_a_q + ADDR_W_A'(m2_q);
                    end
                end else begin
                    j_q      <= j_q + ONE;
                    base_b_q <= base_b_q + ADDR_W_B'(m2_q);
                end
            end else begin
                k_q <= k_q + ONE;
            end
        end
    end

endmodule

// File: rtl/mm_read_ctrl.sv
// rtl/mm_read_ctrl.sv - block sequencer issuing A/B read pairs and done pulses per multiply session
// Optional stall counter built only when MM_RD_CTRL_PERF_EN is defined.
module mm_read_ctrl
    import mm_rd_ctrl_pkg::*;
#(
    parameter int ADDR_W_A     = 12,
    parameter int ADDR_W_B     = 12,
    parameter int MATRIXSIZE_W = 16,
    parameter int DRAIN_CYC    = 8
) (
    input  logic          clk,
    input  logic          rst,
    mm_read_ctrl_if.master bus
);
    localparam int MS_W    = MATRIXSIZE_W;
    localparam int DRAIN_W = cnt_w(DRAIN_CYC);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [MS_W:0]      BLK_ONE    = (MS_W+1)'(1);

    state_e              state_q;
    logic                armed_q;
    logic [MS_W-1:0]     blk_cnt_q;
    logic [MS_W-1:0]     blocks_q;
    logic [DRAIN_W-1:0]  drain_cnt_q;
    logic                rd_en_q, tile_first_q, tile_last_q;
    logic                done_rc_q, done_mul_q;
    logic [ADDR_W_A-1:0] addr_a_q;
    logic [ADDR_W_B-1:0] addr_b_q;

    logic                take_blk, walk_step, more_blocks;
    logic [MS_W:0]       blk_next, blocks_eff;
    logic [ADDR_W_A-1:0] walk_addr_a;
    logic [ADDR_W_B-1:0] walk_addr_b;
    logic                walk_first, walk_last, walk_zero, walk_done;

    // A block may only start on a fresh blk_ready level; armed is re-set by seeing it low.
    assign take_blk   = (state_q == WAIT_BLK) && bus.start_multiply && bus.blk_ready && armed_q;
    assign walk_step  = (state_q == READ) && bus.start_multiply && !walk_zero;
    assign blk_next   = {1'b0, blk_cnt_q} + BLK_ONE;
    assign blocks_eff = (blocks_q == '0) ? BLK_ONE : {1'b0, blocks_q};
    assign more_blocks = (blk_next < blocks_eff);

    mm_addr_walker #(
        .ADDR_W_A     (ADDR_W_A),
        .ADDR_W_B     (ADDR_W_B),
        .MATRIXSIZE_W (MATRIXSIZE_W)
    ) u_walker (
        .clk      (clk),
        .rst      (rst),
        .load_i   (take_blk),
        .step_i   (walk_step),
        .m2_i     (bus.M2),
        .m1_i     (bus.M1dN1),
        .bw_i     (bus.BLOCK_WIDTHdN2),
        .addr_a_o (walk_addr_a),
        .addr_b_o (walk_addr_b),
        .first_o  (walk_first),
        .last_o   (walk_last),
        .zero_o   (walk_zero),
        .done_o   (walk_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            armed_q      <= 1'b1;
            blk_cnt_q    <= '0;
            blocks_q     <= '0;
            drain_cnt_q  <= '0;
            rd_en_q      <= 1'b0;
            tile_first_q <= 1'b0;
            tile_last_q  <= 1'b0;
            done_rc_q    <= 1'b0;
            done_mul_q   <= 1'b0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
        end else begin
            rd_en_q      <= 1'b0;
            tile_first_q <= 1'b0;
            tile_last_q  <= 1'b0;
            done_rc_q    <= 1'b0;
            done_mul_q   <= 1'b0;
            if (!bus.blk_ready) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    blk_cnt_q <= '0;
                    if (bus.start_multiply) begin
                        state_q <= WAIT_BLK;
                    end
                end
                WAIT_BLK: begin
                    if (!bus.start_multiply) begin
                        state_q   <= IDLE;
                        blk_cnt_q <= '0;
                    end else if (take_blk) begin
                        state_q  <= READ;
                        armed_q  <= 1'b0;
                        blocks_q <= bus.BLOCKS;
                    end
                end
                READ: begin
                    if (!bus.start_multiply) begin
                        state_q   <= IDLE;
                        blk_cnt_q <= '0;
                    end else if (walk_zero) begin
                        state_q <= BLK_DONE;
                    end else begin
                        rd_en_q      <= 1'b1;
                        addr_a_q     <= walk_addr_a;
                        addr_b_q     <= walk_addr_b;
                        tile_first_q <= walk_first;
                        tile_last_q  <= walk_last;
                        if (walk_done) begin
                            state_q <= BLK_DONE;
                        end
                    end
                end
                BLK_DONE: begin
                    if (!bus.start_multiply) begin
                        state_q   <= IDLE;
                        blk_cnt_q <= '0;
                    end else begin
                        done_rc_q <= 1'b1;
                        blk_cnt_q <= blk_next[MS_W-1:0];
                        if (more_blocks) begin
                            state_q <= WAIT_BLK;
                        end else begin
                            state_q     <= DRAIN;
                            drain_cnt_q <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (!bus.start_multiply) begin
                        state_q   <= IDLE;
                        blk_cnt_q <= '0;
                    end else if (drain_cnt_q == DRAIN_LAST) begin
                        // Pulse is loaded on entry to DONE so it lands DRAIN_CYC after done_read_control.
                        state_q    <= DONE;
                        done_mul_q <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DRAIN_ONE;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    blk_cnt_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MM_RD_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if ((state_q == IDLE) && bus.start_multiply) begin
            perf_q <= '0;
        end else if ((state_q == WAIT_BLK) && bus.start_multiply && !take_blk &&
                     (perf_q != PERF_MAX)) begin
            perf_q <= perf_q + PERF_W'(1);
        end
    end

    assign bus.perf_stall_cycles = perf_q;
`else
    assign bus.perf_stall_cycles = '0;
`endif

    assign bus.rd_addr_A         = addr_a_q;
    assign bus.rd_addr_B         = addr_b_q;
    assign bus.rd_en             = rd_en_q;
    assign bus.tile_first        = tile_first_q;
    assign bus.tile_last         = tile_last_q;
    assign bus.done_read_control = done_rc_q;
    assign bus.done_multiply     = done_mul_q;

endmodule

// File: tb/tb_mm_read_ctrl.sv
// tb/tb_mm_read_ctrl.sv - scoreboard bench for mm_read_ctrl with a 12-bit and a 4-bit A-address instance
module tb_mm_read_ctrl;
    import mm_rd_ctrl_pkg::*;

    typedef struct packed {
        logic [11:0] a;
        logic [11:0] b;
        logic [3:0]  aw;
        logic        first;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        blk_rdy = 1'b0;
    logic [15:0] m2 = '0, m1 = '0, bw = '0, blocks = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_rd, n_drc, n_dm, n_drc_w, n_dm_w;
    int first_rd_cyc, last_rd_cyc, drc_cyc, dm_cyc;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] exp_perf;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mm_read_ctrl_if #(.ADDR_W_A(12), .ADDR_W_B(12), .MATRIXSIZE_W(16)) bus ();
    mm_read_ctrl_if #(.ADDR_W_A(4),  .ADDR_W_B(12), .MATRIXSIZE_W(16)) bus_w ();

    assign bus.start_multiply   = start;
    assign bus.blk_ready        = blk_rdy;
    assign bus.M2               = m2;
    assign bus.M1dN1            = m1;
    assign bus.BLOCK_WIDTHdN2   = bw;
    assign bus.BLOCKS           = blocks;
    assign bus_w.start_multiply = start;
    assign bus_w.blk_ready      = blk_rdy;
    assign bus_w.M2             = m2;
    assign bus_w.M1dN1          = m1;
    assign bus_w.BLOCK_WIDTHdN2 = bw;
    assign bus_w.BLOCKS         = blocks;

    mm_read_ctrl #(.ADDR_W_A(12), .ADDR_W_B(12), .MATRIXSIZE_W(16), .DRAIN_CYC(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mm_read_ctrl #(.ADDR_W_A(4), .ADDR_W_B(12), .MATRIXSIZE_W(16), .DRAIN_CYC(8)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.rd_en === 1'b1) begin
                    if (n_rd == 0) first_rd_cyc = cyc;
                    n_rd++;
                    last_rd_cyc = cyc;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rd_underflow: rd_en=1 at cycle %0d with no expected beat", cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (bus.rd_addr_A !== mon_e.a || bus.rd_addr_B !== mon_e.b ||
                            bus_w.rd_addr_A !== mon_e.aw || bus_w.rd_addr_B !== mon_e.b ||
                            bus.tile_first !== mon_e.first || bus.tile_last !== mon_e.last ||
                            bus_w.rd_en !== 1'b1) begin
                            errors++;
                            $display("FAIL rd_beat: got A=%0d B=%0d Aw=%0d first=%b last=%b en_w=%b, expected A=%0d B=%0d Aw=%0d first=%b last=%b en_w=1",
                                     bus.rd_addr_A, bus.rd_addr_B, bus_w.rd_addr_A, bus.tile_first,
                                     bus.tile_last, bus_w.rd_en, mon_e.a, mon_e.b, mon_e.aw,
                                     mon_e.first, mon_e.last);
                        end
                    end
                end
                if (bus.done_read_control === 1'b1) begin
                    n_drc++;
                    drc_cyc = cyc;
                end
                if (bus.done_multiply === 1'b1) begin
                    n_dm++;
                    dm_cyc = cyc;
                end
                if (bus_w.done_read_control === 1'b1) n_drc_w++;
                if (bus_w.done_multiply === 1'b1) n_dm_w++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_block(input int m2v, input int m1v, input int bwv);
        exp_t e;
        for (int i = 0; i < m1v; i++)
            for (int j = 0; j < bwv; j++)
                for (int k = 0; k < m2v; k++) begin
                    e.a     = 12'(i * m2v + k);
                    e.b     = 12'(j * m2v + k);
                    e.aw    = 4'(i * m2v + k);
                    e.first = (k == 0);
                    e.last  = (k == m2v - 1);
                    exp_q.push_back(e);
                end
    endtask

    task automatic arm_and_start(output int v);
        blk_rdy = 1'b0;
        @(posedge clk); #1;
        n_rd = 0; n_drc = 0; n_dm = 0; n_drc_w = 0; n_dm_w = 0;
        first_rd_cyc = -1; last_rd_cyc = -1; drc_cyc = -1; dm_cyc = -1;
        blk_rdy = 1'b1;
        start   = 1'b1;
        v = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.rd_en !== 1'b0 || bus.tile_first !== 1'b0 || bus.tile_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got rd_en=%b first=%b last=%b, expected 0 0 0",
                     bus.rd_en, bus.tile_first, bus.tile_last);
        end
        checks++;
        if (bus.rd_addr_A !== 12'd0 || bus.rd_addr_B !== 12'd0) begin
            errors++;
            $display("FAIL reset_addr: got A=%0d B=%0d, expected 0 0", bus.rd_addr_A, bus.rd_addr_B);
        end
        checks++;
        if (bus.done_read_control !== 1'b0 || bus.done_multiply !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got drc=%b dm=%b, expected 0 0",
                     bus.done_read_control, bus.done_multiply);
        end
        checks++;
        if (bus.perf_stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d expected 0", bus.perf_stall_cycles);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int v;
        m2 = 16'd4; m1 = 16'd2; bw = 16'd2; blocks = 16'd1;
        push_block(4, 2, 2);
        arm_and_start(v);
        for (int t = 0; t < 100 && n_rd == 0; t++) begin @(posedge clk); #1; end
        m2 = 16'd3; m1 = 16'd1; bw = 16'd5;
        for (int t = 0; t < 200 && n_dm == 0; t++) begin @(posedge clk); #1; end
        start = 1'b0;
        m2 = 16'd4; m1 = 16'd2; bw = 16'd2;
        checks++;
        if (n_rd !== 16) begin
            errors++; $display("FAIL basic_rd_count: got %0d expected 16", n_rd);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL basic_leftover: got %0d expected 0", exp_q.size());
        end
        checks++;
        if (first_rd_cyc !== v + 3) begin
            errors++; $display("FAIL basic_first_latency: got %0d expected %0d", first_rd_cyc, v + 3);
        end
        checks++;
        if (n_drc !== 1 || drc_cyc !== last_rd_cyc + 1) begin
            errors++;
            $display("FAIL basic_drc: got count %0d at %0d, expected 1 at %0d", n_drc, drc_cyc, last_rd_cyc + 1);
        end
        checks++;
        if (n_dm !== 1 || dm_cyc !== drc_cyc + 8) begin
            errors++;
            $display("FAIL basic_dm: got count %0d at %0d, expected 1 at %0d", n_dm, dm_cyc, drc_cyc + 8);
        end
    endtask

    task automatic test_multi_block();
        int v;
        m2 = 16'd2; m1 = 16'd1; bw = 16'd1; blocks = 16'd3;
        push_block(2, 1, 1);
        arm_and_start(v);
        for (int t = 0; t < 100 && n_drc == 0; t++) begin @(posedge clk); #1; end
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (n_drc !== 1 || n_rd !== 2 || n_dm !== 0) begin
            errors++;
            $display("FAIL multi_held_ready: got drc=%0d rd=%0d dm=%0d, expected 1 2 0", n_drc, n_rd, n_dm);
        end
        for (int b = 1; b < 3; b++) begin
            push_block(2, 1, 1);
            blk_rdy = 1'b0;
            @(posedge clk); #1;
            blk_rdy = 1'b1;
            for (int t = 0; t < 100 && n_drc <= b; t++) begin @(posedge clk); #1; end
        end
        for (int t = 0; t < 100 && n_dm == 0; t++) begin @(posedge clk); #1; end
        start = 1'b0;
        checks++;
        if (n_drc !== 3 || n_dm !== 1 || n_rd !== 6) begin
            errors++;
            $display("FAIL multi_counts: got drc=%0d dm=%0d rd=%0d, expected 3 1 6", n_drc, n_dm, n_rd);
        end
        checks++;
        if (dm_cyc !== drc_cyc + 8) begin
            errors++; $display("FAIL multi_dm_timing: got %0d expected %0d", dm_cyc, drc_cyc + 8);
        end
    endtask

    task automatic test_abort();
        int v;
        m2 = 16'd4; m1 = 16'd2; bw = 16'd2; blocks = 16'd1;
        push_block(4, 2, 2);
        arm_and_start(v);
        for (int t = 0; t < 100 && n_rd < 5; t++) begin @(negedge clk); #1; end
        start = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.rd_en !== 1'b0) begin
            errors++; $display("FAIL abort_rd_en: got %b expected 0", bus.rd_en);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (n_rd !== 5 || n_drc !== 0 || n_dm !== 0) begin
            errors++;
            $display("FAIL abort_counts: got rd=%0d drc=%0d dm=%0d, expected 5 0 0", n_rd, n_drc, n_dm);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++; $display("FAIL abort_state: got %0d expected %0d", dut.state_q, IDLE);
        end
        exp_q.delete();
    endtask

    task automatic test_zero();
        int v;
        m2 = 16'd0; m1 = 16'd2; bw = 16'd2; blocks = 16'd1;
        arm_and_start(v);
        for (int t = 0; t < 100 && n_dm == 0; t++) begin @(posedge clk); #1; end
        start = 1'b0;
        checks++;
        if (n_rd !== 0) begin
            errors++; $display("FAIL zero_rd: got %0d expected 0", n_rd);
        end
        checks++;
        if (n_drc !== 1 || drc_cyc !== v + 4) begin
            errors++;
            $display("FAIL zero_drc: got count %0d at %0d, expected 1 at %0d", n_drc, drc_cyc, v + 4);
        end
        checks++;
        if (n_dm !== 1 || dm_cyc !== drc_cyc + 8) begin
            errors++;
            $display("FAIL zero_dm: got count %0d at %0d, expected 1 at %0d", n_dm, dm_cyc, drc_cyc + 8);
        end
    endtask

    task automatic test_wrap();
        int v;
        m2 = 16'd8; m1 = 16'd3; bw = 16'd1; blocks = 16'd0;
        push_block(8, 3, 1);
        arm_and_start(v);
        for (int t = 0; t < 200 && n_dm == 0; t++) begin @(posedge clk); #1; end
        start = 1'b0;
        checks++;
        if (n_rd !== 24 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL wrap_count: got rd=%0d left=%0d, expected 24 0", n_rd, exp_q.size());
        end
        checks++;
        if (n_drc_w !== 1 || n_dm_w !== 1) begin
            errors++;
            $display("FAIL wrap_narrow_done: got drc=%0d dm=%0d, expected 1 1", n_drc_w, n_dm_w);
        end
    endtask

    task automatic test_perf();
        m2 = 16'd1; m1 = 16'd1; bw = 16'd1; blocks = 16'd1;
        push_block(1, 1, 1);
        blk_rdy = 1'b0;
        @(posedge clk); #1;
        n_rd = 0; n_drc = 0; n_dm = 0;
        start = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        blk_rdy = 1'b1;
        for (int t = 0; t < 100 && n_dm == 0; t++) begin @(posedge clk); #1; end
        start = 1'b0;
`ifdef MM_RD_CTRL_PERF_EN
        exp_perf = 32'd10;
`else
        exp_perf = 32'd0;
`endif
        checks++;
        if (bus.perf_stall_cycles !== exp_perf || bus_w.perf_stall_cycles !== exp_perf) begin
            errors++;
            $display("FAIL perf_stall: got %0d/%0d expected %0d",
                     bus.perf_stall_cycles, bus_w.perf_stall_cycles, exp_perf);
        end
        checks++;
        if (n_rd !== 1 || n_dm !== 1) begin
            errors++; $display("FAIL perf_session: got rd=%0d dm=%0d expected 1 1", n_rd, n_dm);
        end
    endtask

    task automatic test_rst_mid();
        int v;
        m2 = 16'd4; m1 = 16'd2; bw = 16'd2; blocks = 16'd1;
        push_block(4, 2, 2);
        arm_and_start(v);
        for (int t = 0; t < 100 && n_rd < 3; t++) begin @(negedge clk); #1; end
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.rd_en !== 1'b0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL rst_mid_stop: got rd_en=%b state=%0d expected 0 %0d", bus.rd_en, dut.state_q, IDLE);
        end
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (n_rd !== 3 || n_drc !== 0 || n_dm !== 0) begin
            errors++;
            $display("FAIL rst_mid_counts: got rd=%0d drc=%0d dm=%0d expected 3 0 0", n_rd, n_drc, n_dm);
        end
        exp_q.delete();
    endtask

    initial begin
        n_rd = 0; n_drc = 0; n_dm = 0; n_drc_w = 0; n_dm_w = 0;
        first_rd_cyc = -1; last_rd_cyc = -1; drc_cyc = -1; dm_cyc = -1;
        test_reset();
        test_basic();
        test_multi_block();
        test_abort();
        test_zero();
        test_wrap();
        test_perf();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
